// File: rtl/req_rsp_loopback_mc.sv
// Multi-channel request/response loopback with a DEPTH-entry FIFO per channel.
// Each channel optionally transforms beats at enqueue (mode sampled at push)
// and returns them in order on its own valid/ready response port.

module req_rsp_loopback_lane #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    parameter int CH     = 0,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              run,
    input  logic [1:0]        mode,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [LW-1:0]     level,
    output logic [CNT_W-1:0]  rsp_count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [DATA_W-1:0] wdata;
    logic              push;
    logic              pop;

    // Ready comes only from registered state; flush masks it so no beat is
    // accepted (and therefore lost) in a flush cycle. Full never falls through.
    assign req_ready = run & ~flush & (level < LW'(DEPTH));
    assign rsp_valid = (level != '0);
    assign rsp_data  = mem[rptr];
    assign push      = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready & ~flush;

    // Transform applied on the way into the FIFO so later mode changes
    // leave queued entries untouched.
    always_comb begin
        wdata = req_data;
        case (mode)
            2'd0:    wdata = req_data;
            2'd1:    wdata = req_data + DATA_W'(1);
            2'd2:    wdata = ~req_data;
            default: wdata = req_data ^ DATA_W'(CH);
        endcase
    end

    // Storage is cleared on reset so the head never presents X.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy; flush empties the FIFO and wins over any transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Completed-response counter; survives flush, wraps naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  rsp_count <= '0;
        else if (pop)  rsp_count <= rsp_count + CNT_W'(1);
    end

endmodule

module req_rsp_loopback_mc #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [1:0]               mode,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        rsp_valid,
    input  logic [NUM_CH-1:0]        rsp_ready,
    output logic [NUM_CH*DATA_W-1:0] rsp_data,
    output logic [NUM_CH*LW-1:0]     level,
    output logic [NUM_CH*CNT_W-1:0]  rsp_count
);

    logic run;

    // Ready is held low through reset and the deassertion cycle, then set
    // on the first clock edge out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) run <= 1'b0;
        else          run <= 1'b1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        req_rsp_loopback_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W),
            .CH     (g)
        ) u_lane (
            .clock     (clock),
            .reset_n   (reset_n),
            .flush     (flush),
            .run       (run),
            .mode      (mode),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_data  (req_data[g*DATA_W +: DATA_W]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_data  (rsp_data[g*DATA_W +: DATA_W]),
            .level     (level[g*LW +: LW]),
            .rsp_count (rsp_count[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_req_rsp_loopback_mc.sv
// Bench for req_rsp_loopback_mc: directed steps followed by random traffic,
// every cycle compared against a queue-based channel model.

module tb_req_rsp_loopback_mc;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic                     clock = 1'b0;
    logic                     reset_n;
    logic                     flush;
    logic [1:0]               mode;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [NUM_CH-1:0]        rsp_ready;
    logic [NUM_CH*DATA_W-1:0] rsp_data;
    logic [NUM_CH*LW-1:0]     level;
    logic [NUM_CH*CNT_W-1:0]  rsp_count;

    req_rsp_loopback_mc #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .mode      (mode),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .level     (level),
        .rsp_count (rsp_count)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one FIFO queue and one pop counter per channel.
    logic [DATA_W-1:0] q [NUM_CH][$];
    int                cnt_m [NUM_CH];
    bit                run_m;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] xf(logic [1:0] m, int c, logic [DATA_W-1:0] d);
        case (m)
            2'd0:    return d;
            2'd1:    return d + DATA_W'(1);
            2'd2:    return ~d;
            default: return d ^ DATA_W'(c);
        endcase
    endfunction

    function automatic bit exp_ready(int c);
        return run_m && (q[c].size() < DEPTH) && !flush;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            q[c].delete();
            cnt_m[c] = 0;
        end
        run_m = 0;
    endtask

    task automatic check_model();
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("req_ready[%0d]", c), 64'(req_ready[c]), 64'(exp_ready(c)));
            chk($sformatf("rsp_valid[%0d]", c), 64'(rsp_valid[c]), 64'(q[c].size() != 0));
            if (q[c].size() != 0)
                chk($sformatf("rsp_data[%0d]", c), 64'(rsp_data[c*DATA_W +: DATA_W]), 64'(q[c][0]));
            chk($sformatf("level[%0d]", c), 64'(level[c*LW +: LW]), 64'(q[c].size()));
            chk($sformatf("rsp_count[%0d]", c), 64'(rsp_count[c*CNT_W +: CNT_W]), 64'(cnt_m[c]));
        end
    endtask

    // One clock: called right after a falling edge with inputs already driven.
    task automatic cycle();
        bit                do_push [NUM_CH];
        bit                do_pop  [NUM_CH];
        logic [DATA_W-1:0] val     [NUM_CH];
        bit                fl;
        #1;
        check_model();
        fl = flush;
        for (int c = 0; c < NUM_CH; c++) begin
            do_push[c] = req_valid[c] && exp_ready(c);
            do_pop[c]  = (q[c].size() != 0) && rsp_ready[c] && !flush;
            val[c]     = xf(mode, c, req_data[c*DATA_W +: DATA_W]);
        end
        @(posedge clock);
        if (reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (fl) begin
                    q[c].delete();
                end else begin
                    if (do_pop[c]) begin
                        void'(q[c].pop_front());
                        cnt_m[c] = (cnt_m[c] + 1) % (1 << CNT_W);
                    end
                    if (do_push[c]) q[c].push_back(val[c]);
                end
            end
            run_m = 1;
        end
        @(negedge clock);
    endtask

    task automatic set_beat(int c, logic [DATA_W-1:0] d);
        req_valid    = '0;
        req_valid[c] = 1'b1;
        req_data[c*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        int            start;
        logic [CNT_W-1:0] cnt_before;

        reset_n   = 1'b0;
        flush     = 1'b0;
        mode      = 2'd0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = '0;
        model_reset();
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_level",     64'(level),     64'(0));
        chk("reset_rsp_count", 64'(rsp_count), 64'(0));
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        cycle();                                  // deassertion cycle, ready still 0

        // Single beat through ch0 with mode 0
        rsp_ready = '1;
        set_beat(0, 32'h0000_00A5);
        cycle();
        req_valid = '0;
        chk("single_rsp_valid", 64'(rsp_valid[0]), 64'(1));
        chk("single_rsp_data",  64'(rsp_data[31:0]), 64'h0000_00A5);
        cycle();
        chk("single_rsp_count", 64'(rsp_count[CNT_W-1:0]), 64'(1));
        chk("single_ch1_level", 64'(level[2*LW-1:LW]), 64'(0));

        // Modes, with mode switched after push but before pop
        rsp_ready = '0;
        mode = 2'd1; set_beat(0, 32'hFFFF_FFFF); cycle();
        req_valid = '0; mode = 2'd0;
        chk("mode1_wrap", 64'(rsp_data[31:0]), 64'h0);
        rsp_ready = '1; cycle();
        rsp_ready = '0;
        mode = 2'd2; set_beat(0, 32'h1234_5678); cycle();
        req_valid = '0; mode = 2'd3; cycle();
        chk("mode2_invert_held", 64'(rsp_data[31:0]), 64'hEDCB_A987);
        rsp_ready = '1; cycle();
        rsp_ready = '0;
        mode = 2'd3; set_beat(1, 32'h10); cycle();
        req_valid = '0; mode = 2'd0;
        chk("mode3_xor_ch1", 64'(rsp_data[63:32]), 64'h11);
        rsp_ready = '1; cycle();

        // Fill ch0 under backpressure, then full with simultaneous pop
        rsp_ready = '0;
        for (int i = 1; i <= 4; i++) begin
            set_beat(0, DATA_W'(i));
            cycle();
        end
        set_beat(0, 32'd5);
        cycle();
        chk("full_level", 64'(level[LW-1:0]), 64'(4));
        chk("full_ready", 64'(req_ready[0]), 64'(0));
        rsp_ready[0] = 1'b1;
        cycle();
        chk("full_pop_only_level", 64'(level[LW-1:0]), 64'(3));
        cycle();                                  // beat 5 enters while beat 2 leaves
        req_valid = '0;
        for (int i = 0; i < 8 && q[0].size() != 0; i++) cycle();
        chk("drain_empty", 64'(rsp_valid[0]), 64'(0));

        // Flush mid-stream with a push in the same cycle
        rsp_ready = '0;
        for (int i = 0; i < 3; i++) begin
            set_beat(0, $urandom);
            cycle();
        end
        cnt_before = rsp_count[CNT_W-1:0];
        flush = 1'b1;
        set_beat(0, 32'hDEAD_BEEF);
        cycle();
        flush = 1'b0;
        chk("flush_level",     64'(level[LW-1:0]), 64'(0));
        chk("flush_rsp_valid", 64'(rsp_valid[0]), 64'(0));
        chk("flush_count",     64'(rsp_count[CNT_W-1:0]), 64'(cnt_before));
        cycle();
        req_valid = '0;
        chk("post_flush_push", 64'(level[LW-1:0]), 64'(1));
        cycle();

        // Async reset between edges with level 2
        set_beat(0, $urandom);
        cycle();
        req_valid = '0;
        chk("pre_reset_level", 64'(level[LW-1:0]), 64'(2));
        #2 reset_n = 1'b0;
        #1;
        chk("areset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("areset_req_ready", 64'(req_ready), 64'(0));
        chk("areset_level",     64'(level),     64'(0));
        chk("areset_rsp_count", 64'(rsp_count), 64'(0));
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        cycle();

        // Counter wrap: 17 pops with a 4-bit counter
        rsp_ready = '1;
        for (int i = 0; i < 17; i++) begin
            mode = 2'($urandom_range(3));
            set_beat(0, $urandom);
            cycle();
        end
        req_valid = '0;
        for (int i = 0; i < 8 && q[0].size() != 0; i++) cycle();
        chk("count_wrap", 64'(rsp_count[CNT_W-1:0]), 64'(1));

        // Random traffic on all channels
        start = n_assert;
        for (int i = 0; i < 400; i++) begin
            flush     = ($urandom_range(29) == 0);
            mode      = 2'($urandom_range(3));
            req_valid = NUM_CH'($urandom);
            rsp_ready = NUM_CH'($urandom);
            for (int c = 0; c < NUM_CH; c++) req_data[c*DATA_W +: DATA_W] = $urandom;
            cycle();
        end
        flush = 1'b0; req_valid = '0; rsp_ready = '1;
        for (int i = 0; i < 2 * DEPTH; i++) cycle();
        chk("random_ran", 64'(n_assert > start), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
